// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave controller: FSM states,
// post-frame phases, command codes and a frame-building helper.
package spi_pkg;

    localparam int FRAME_W_DEFAULT = 10;
    localparam int DATA_W_DEFAULT  = 8;
    localparam int CNT_W           = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_CMD,
        ST_WRITE,
        ST_READ_ADD,
        ST_READ_DATA
    } state_t;

    // Sub-phase inside WRITE/READ_ADD/READ_DATA once the lead bit is consumed.
    typedef enum logic [1:0] {
        PH_FRAME,
        PH_WAIT_TX,
        PH_SHIFT_TX,
        PH_HOLD
    } phase_t;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_t;

    function automatic logic [FRAME_W_DEFAULT-1:0] make_frame(input cmd_t cmd,
                                                              input logic [7:0] payload);
        return {cmd, payload};
    endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Serial and RAM-side signals of the SPI slave, bundled with a slave view
// for the controller and a master view for whoever drives it.
interface spi_slave_ctrl_if #(
    parameter int FRAME_W = spi_pkg::FRAME_W_DEFAULT,
    parameter int DATA_W  = spi_pkg::DATA_W_DEFAULT
) ();

    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_rx_shift.sv
// MOSI-to-parallel shifter with its own bit counter; flags the edge that
// captures the last bit of a frame and presents the completed frame.
module spi_rx_shift
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_shift_en,
    input  logic               i_mosi,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_count_done
);

    logic [FRAME_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;

    // o_frame already includes the bit being sampled, so the parent can load
    // the full frame on the same edge that captures bit 0.
    assign o_frame      = {r_shift[FRAME_W-2:0], i_mosi};
    assign o_count_done = i_shift_en && (r_bit_cnt == CNT_W'(FRAME_W - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (i_clear) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (i_shift_en) begin
            r_shift   <= o_frame;
            r_bit_cnt <= o_count_done ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave controller: decodes the lead bit, collects FRAME_W-bit frames for
// the RAM, tracks the read-address flag and serialises read data onto MISO.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_slave_ctrl_if.slave   bus
);

    localparam int TX_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              r_state;
    phase_t              r_phase;
    logic                r_rd_addr_flag;
    logic [FRAME_W-1:0]  r_rx_data;
    logic                r_rx_valid;
    logic                r_miso;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [TX_CNT_W-1:0] r_tx_cnt;

    state_t              w_state_nxt;
    phase_t              w_phase_nxt;
    logic                w_rd_addr_flag_nxt;
    logic [FRAME_W-1:0]  w_rx_data_nxt;
    logic                w_rx_valid_nxt;
    logic                w_miso_nxt;
    logic [DATA_W-1:0]   w_tx_shift_nxt;
    logic [TX_CNT_W-1:0] w_tx_cnt_nxt;

    logic                w_in_frame_state;
    logic                w_shift_en;
    logic                w_clear;
    logic [FRAME_W-1:0]  w_frame;
    logic                w_count_done;

    assign w_in_frame_state = (r_state == ST_WRITE) || (r_state == ST_READ_ADD) ||
                              (r_state == ST_READ_DATA);
    assign w_shift_en = w_in_frame_state && (r_phase == PH_FRAME) && !bus.SS_n;
    assign w_clear    = bus.SS_n || (r_state == ST_IDLE) || (r_state == ST_CHK_CMD);

    spi_rx_shift #(.FRAME_W(FRAME_W)) u_rx_shift (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_shift_en   (w_shift_en),
        .i_mosi       (bus.MOSI),
        .o_frame      (w_frame),
        .o_count_done (w_count_done)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt        = r_state;
        w_phase_nxt        = r_phase;
        w_rd_addr_flag_nxt = r_rd_addr_flag;
        w_rx_data_nxt      = r_rx_data;
        w_rx_valid_nxt     = 1'b0;
        w_miso_nxt         = 1'b0;
        w_tx_shift_nxt     = r_tx_shift;
        w_tx_cnt_nxt       = r_tx_cnt;

        // Deselect outranks frame completion and tx_valid on the same edge.
        if ((r_state != ST_IDLE) && bus.SS_n) begin
            w_state_nxt    = ST_IDLE;
            w_phase_nxt    = PH_FRAME;
            w_tx_shift_nxt = '0;
            w_tx_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_phase_nxt = PH_FRAME;
                    if (!bus.SS_n) w_state_nxt = ST_CHK_CMD;
                end
                ST_CHK_CMD: begin
                    if (!bus.MOSI)          w_state_nxt = ST_WRITE;
                    else if (r_rd_addr_flag) w_state_nxt = ST_READ_DATA;
                    else                     w_state_nxt = ST_READ_ADD;
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    unique case (r_phase)
                        PH_FRAME: begin
                            if (w_count_done) begin
                                w_rx_data_nxt  = w_frame;
                                w_rx_valid_nxt = 1'b1;
                                w_phase_nxt    = PH_HOLD;
                                if (r_state == ST_READ_ADD) w_rd_addr_flag_nxt = 1'b1;
                                if (r_state == ST_READ_DATA) begin
                                    w_rd_addr_flag_nxt = 1'b0;
                                    w_phase_nxt        = PH_WAIT_TX;
                                end
                            end
                        end
                        PH_WAIT_TX: begin
                            if (bus.tx_valid) begin
                                w_tx_shift_nxt = bus.tx_data;
                                w_tx_cnt_nxt   = '0;
                                w_phase_nxt    = PH_SHIFT_TX;
                            end
                        end
                        PH_SHIFT_TX: begin
                            w_miso_nxt     = r_tx_shift[DATA_W-1];
                            w_tx_shift_nxt = {r_tx_shift[DATA_W-2:0], 1'b0};
                            w_tx_cnt_nxt   = r_tx_cnt + TX_CNT_W'(1);
                            if (r_tx_cnt == TX_CNT_W'(DATA_W - 1)) w_phase_nxt = PH_HOLD;
                        end
                        PH_HOLD: ;
                    endcase
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = PH_FRAME;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_phase        <= PH_FRAME;
            r_rd_addr_flag <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_miso         <= 1'b0;
            r_tx_shift     <= '0;
            r_tx_cnt       <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_phase        <= w_phase_nxt;
            r_rd_addr_flag <= w_rd_addr_flag_nxt;
            r_rx_data      <= w_rx_data_nxt;
            r_rx_valid     <= w_rx_valid_nxt;
            r_miso         <= w_miso_nxt;
            r_tx_shift     <= w_tx_shift_nxt;
            r_tx_cnt       <= w_tx_cnt_nxt;
        end
    end

    assign bus.MISO     = r_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 Parameter: FRAME_W, 10, bits per MOSI frame ({cmd[1:0], payload[7:0]}).
REQ-002 Parameter: DATA_W, 8, read-data width shifted out on MISO.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: SS_n  in  1  slave select, active low; synchronous to clk.
REQ-006 Port: MOSI  in  1  serial data in, MSB first, one bit per clk.
REQ-007 Port: MISO  out  1  serial data out, MSB first, one bit per clk.
REQ-008 Port: rx_data  out  FRAME_W  assembled frame to RAM din.
REQ-009 Port: rx_valid  out  1  one-cycle strobe qualifying rx_data.
REQ-010 Port: tx_data  in  DATA_W  read data from RAM dout.
REQ-011 Port: tx_valid  in  1  qualifies tx_data.

Function
REQ-012 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-013 IDLE -> CHK_CMD on rising edge sampling SS_n=0; otherwise stay IDLE.
REQ-014 CHK_CMD samples MOSI as lead bit: 0 -> WRITE; 1 and rd_addr_flag=0 -> READ_ADD; 1 and rd_addr_flag=1 -> READ_DATA; lead bit not stored.
REQ-015 WRITE/READ_ADD/READ_DATA SHALL shift exactly FRAME_W MOSI bits, MSB first, into a shift register via a 4-bit bit counter.
REQ-016 On the edge capturing bit 0, rx_data SHALL load the full frame and rx_valid SHALL be 1 for exactly the following cycle.
REQ-017 rx_data SHALL hold its value until the next completed frame.
REQ-018 Completed READ_ADD frame sets rd_addr_flag; completed READ_DATA frame clears it; WRITE frames leave it unchanged.
REQ-019 WRITE/READ_ADD: after the frame, FSM holds (no further shifting, no strobes) until SS_n=1.
REQ-020 READ_DATA: after the frame, wait for tx_valid=1; on that edge capture tx_data; MISO drives bit DATA_W-1 from the next edge, then one lower bit per edge, DATA_W cycles total.
REQ-021 After bit 0 is driven for one cycle, MISO SHALL return to 0 and FSM holds until SS_n=1.
REQ-022 tx_valid SHALL be ignored outside the READ_DATA wait phase; a second tx_valid during shifting SHALL be ignored.
REQ-023 SS_n=1 sampled in any non-IDLE state SHALL force IDLE next cycle, clear bit counter, drive MISO 0, abort without rx_valid.
REQ-024 SS_n=1 on the edge capturing bit 0 SHALL win: frame discarded, no rx_valid, rd_addr_flag unchanged.
REQ-025 SS_n=1 together with tx_valid SHALL win: no capture, no MISO shifting.
REQ-026 MISO SHALL be 0 whenever not shifting read data.

Reset
REQ-027 rst_n=0 SHALL immediately set state=IDLE, MISO=0, rx_valid=0, rx_data=0, rd_addr_flag=0, counters and shift registers 0.
REQ-028 Reset mid-frame or mid-read SHALL discard all progress; first post-reset frame behaves as after power-up.

Structure
REQ-029 Shared package spi_pkg SHALL hold the state enum, command codes (WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11), FRAME_W and DATA_W defaults.
REQ-030 FSM, counters and flag in spi_slave_ctrl; MOSI-to-parallel shifter SHALL be a sub-module spi_rx_shift (shift enable, count-done output).

Verification
REQ-031 SS_n low, lead 0, frame 10'b00_0000_0101 -> rx_valid one cycle, rx_data=10'h005; then frame 01_1010_1010 in new transaction -> rx_data=10'h1AA.
REQ-032 Lead 1, frame 10'h205 (READ_ADD) -> rx_valid, rd_addr_flag=1; next transaction lead 1, frame 10'h300 -> READ_DATA entered, rx_data=10'h300.
REQ-033 In READ_DATA after frame, tx_valid=1 with tx_data=8'hA5 -> MISO 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0; rd_addr_flag=0.
REQ-034 SS_n raised after 6 of 10 bits -> no rx_valid, IDLE next cycle; following full frame 10'h0FF -> rx_data=10'h0FF.
REQ-035 rst_n pulsed low mid-MISO shift of 8'h3C -> MISO=0, state IDLE immediately; next lead-1 frame enters READ_ADD (flag cleared).
REQ-036 SS_n rises same edge as tx_valid=1 (tx_data=8'hFF) -> MISO stays 0, IDLE next cycle.
